mgt_01_fp_add_sub_arbiter: RTL

//  Shares one MGT_01_fp_add_sub_IP instance between N_REQ requesters (FP issue slots).
//  - Round-robin arbitration; accepted operands and tag are registered.
//  - Sequences the FU until fu_state_i reports VALID.
//  - Holds the result in a 1-entry writeback buffer until the consumer accepts it.
//  - One operation in flight at a time.

---
 rtl/mgt_01_fp_add_sub_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mgt_01_fp_add_sub_arbiter.sv
// Round-robin arbiter sharing one FP add/sub unit between N_REQ issue slots:
// one op in flight, watchdog on the FU, 1-entry writeback buffer.
// fu_state_i encoding (fu_state_e): 2'd0 idle, 2'd1 busy, 2'd2 valid.
module mgt_01_fp_add_sub_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TAG_W   = 5,
    parameter int MAX_LAT = 16,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clk_en_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*32-1:0]    req_op_a_i,
    input  logic [N_REQ*32-1:0]    req_op_b_i,
    input  logic [N_REQ*7-1:0]     req_funct7_i,
    input  logic [N_REQ*TAG_W-1:0] req_tag_i,
    output logic [31:0]            fu_op_A_o,
    output logic [31:0]            fu_op_B_o,
    output logic [6:0]             fu_funct7_o,
    output logic                   fu_clk_en_o,
    input  logic [31:0]            fu_result_i,
    input  logic [1:0]             fu_state_i,
    input  logic [2:0]             fu_flags_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [31:0]            wb_result_o,
    output logic [TAG_W-1:0]       wb_tag_o,
    output logic [ID_W-1:0]        wb_id_o,
    output logic [3:0]             wb_flags_o
);

    localparam int         WD_W     = $clog2(MAX_LAT);
    localparam logic [1:0] FU_VALID = 2'd2;
    localparam logic [31:0] QNAN    = 32'h7fc0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_next_s;
    logic [ID_W-1:0]   ptr_r;
    logic [WD_W-1:0]   wdog_r;
    logic [TAG_W-1:0]  tag_r;
    logic [ID_W-1:0]   id_r;
    logic [ID_W:0]     pick_s;
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              accept_s;
    logic              fu_valid_s;
    logic              wdog_last_s;
    logic              exec_done_s;

    // First valid requester at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        int              cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            else               cand = cand;
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Round-robin winner selection.
    always_comb begin
        pick_s = rr_pick(req_valid_i, ptr_r);
    end

    assign grant_found_s = pick_s[ID_W];
    assign grant_idx_s   = pick_s[ID_W-1:0];
    assign accept_s      = clk_en_i && (state_r == ST_IDLE) && grant_found_s;
    assign fu_valid_s    = (state_r == ST_EXEC) && (fu_state_i == FU_VALID);
    assign wdog_last_s   = (wdog_r == WD_W'(MAX_LAT - 1));
    assign exec_done_s   = (state_r == ST_EXEC) && (fu_valid_s || wdog_last_s);
    assign fu_clk_en_o   = clk_en_i && (state_r == ST_EXEC);

    // One-hot grant, only offered in IDLE while enabled.
    always_comb begin
        req_ready_o = '0;
        if (accept_s) begin
            req_ready_o[grant_idx_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) state_next_s = ST_EXEC;
                else               state_next_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (fu_valid_s || wdog_last_s) state_next_s = ST_DONE;
                else                           state_next_s = ST_EXEC;
            end
            ST_DONE: begin
                if (wb_ready_i) state_next_s = ST_IDLE;
                else            state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, frozen while the global enable is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else if (clk_en_i) begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, rr pointer, watchdog and writeback buffer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_r       <= '0;
            wdog_r      <= '0;
            tag_r       <= '0;
            id_r        <= '0;
            fu_op_A_o   <= 32'h0000_0000;
            fu_op_B_o   <= 32'h0000_0000;
            fu_funct7_o <= 7'd0;
            wb_valid_o  <= 1'b0;
            wb_result_o <= 32'h0000_0000;
            wb_tag_o    <= '0;
            wb_id_o     <= '0;
            wb_flags_o  <= 4'b0000;
        end else if (clk_en_i) begin
            if (accept_s) begin
                fu_op_A_o   <= req_op_a_i[32*int'(grant_idx_s) +: 32];
                fu_op_B_o   <= req_op_b_i[32*int'(grant_idx_s) +: 32];
                fu_funct7_o <= req_funct7_i[7*int'(grant_idx_s) +: 7];
                tag_r       <= req_tag_i[TAG_W*int'(grant_idx_s) +: TAG_W];
                id_r        <= grant_idx_s;
                ptr_r       <= (grant_idx_s == ID_W'(N_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
            end
            if (state_r == ST_EXEC) begin
                wdog_r <= exec_done_s ? '0 : wdog_r + WD_W'(1);
            end
            // VALID has priority over the watchdog, even on its last cycle.
            if (exec_done_s) begin
                wb_valid_o  <= 1'b1;
                wb_result_o <= fu_valid_s ? fu_result_i : QNAN;
                wb_flags_o  <= fu_valid_s ? {1'b0, fu_flags_i} : 4'b1100;
                wb_tag_o    <= tag_r;
                wb_id_o     <= id_r;
            end else if ((state_r == ST_DONE) && wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

endmodule
